// File: rtl/sim_ram_copier_pkg.sv
// Shared types and helpers for the simulation-RAM block copier.
//   state_e     : copier FSM states
//   overlap_bad : true when a forward copy would overwrite source words before they are read
package sim_ram_copier_pkg;

    // Wide enough for any supported ADDR_WIDTH; callers zero-extend into it.
    localparam int unsigned OVL_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // diff is (dst - src) modulo the address space, so wrap-around overlaps are caught too.
    function automatic logic overlap_bad(input logic [OVL_W-1:0] diff, input logic [OVL_W:0] len);
        return (diff != '0) && ({1'b0, diff} < len);
    endfunction

endpackage

// File: rtl/sim_ram_copier.sv
// Block copier (memcpy semantics) driving the read and write ports of the simulation RAM.
// One read is issued per cycle; each returned word is written to the destination in the
// cycle its response arrives. Destructive forward overlaps are rejected with an err pulse.
//   clk, rst_n                  : clock, async active-low reset
//   start, src_addr, dst_addr,
//   len                         : copy request, sampled only while idle
//   idle, busy, done, err       : status (done/err are one-cycle pulses)
//   ram_rd_en/addr, ram_rd_data,
//   ram_rd_valid                : RAM read port (response one cycle after ram_rd_en)
//   ram_wr_en/addr/data         : RAM write port (combinational from the read response)
module sim_ram_copier
    import sim_ram_copier_pkg::*;
#(
    parameter int unsigned DATA_SIZE_BYTES = 1,
    parameter int unsigned ADDR_WIDTH      = 8,
    localparam int unsigned DATA_WIDTH     = DATA_SIZE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  idle,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    input  logic                  ram_rd_valid,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data
);

    localparam int unsigned     CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      wr_idx_q, wr_idx_d;

    logic [ADDR_WIDTH-1:0] diff_c;
    logic                  active_c;
    logic                  wr_fire_c;

    assign diff_c    = dst_addr - src_addr;
    assign active_c  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // The RAM's rd_valid is unreset, so it is only trusted while a copy is running.
    assign wr_fire_c = active_c && ram_rd_valid;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;

        if (wr_fire_c) begin
            wr_idx_d = wr_idx_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    len_d    = len;
                    rd_idx_d = '0;
                    wr_idx_d = '0;
                    if (overlap_bad(OVL_W'(diff_c), (OVL_W+1)'(len))) begin
                        state_d = ST_ERR;
                    end else if ((len == '0) || (diff_c == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rd_idx_d = rd_idx_q + CNT_ONE;
                if (rd_idx_q == len_q - CNT_ONE) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The final response always lands here, one cycle after the last read.
                if (wr_fire_c && (wr_idx_q == len_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status and RAM port decode; addresses and data are held at zero when not in use.
    assign idle        = (state_q == ST_IDLE);
    assign busy        = active_c;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);
    assign ram_rd_en   = (state_q == ST_RUN);
    assign ram_rd_addr = ram_rd_en ? (src_q + rd_idx_q[ADDR_WIDTH-1:0]) : '0;
    assign ram_wr_en   = wr_fire_c;
    assign ram_wr_addr = wr_fire_c ? (dst_q + wr_idx_q[ADDR_WIDTH-1:0]) : '0;
    assign ram_wr_data = wr_fire_c ? ram_rd_data : '0;

    // A read and a write never hit the same word in one cycle.
    a_no_rw_clash: assert property (@(posedge clk) disable iff (!rst_n)
        !(ram_rd_en && ram_wr_en && (ram_rd_addr == ram_wr_addr)));

    // Responses seen during a copy must answer a read issued the cycle before.
    a_valid_follows_rd: assert property (@(posedge clk) disable iff (!rst_n)
        (busy && ram_rd_valid) |-> $past(ram_rd_en));

endmodule

// File: doc/sim_ram_copier.md
Name: sim_ram_copier

Overview:
- Initiator-side engine that drives the simulation RAM's read and write ports to copy a block of words within that RAM (memcpy semantics).
- Sits between a testbench or CPU-side control stub and the RAM instance.
- Issues one read per cycle and writes each returned word to the destination on the cycle its read response arrives.
- Rejects destructive overlaps and flags them.

Parameters:
- DATA_SIZE_BYTES, 1, word size in bytes; DATA_WIDTH = DATA_SIZE_BYTES*8 (derived, not overridable).
- ADDR_WIDTH, 8, RAM word-address width; all address arithmetic is modulo 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  copy request; sampled only while idle=1.
- src_addr  in  ADDR_WIDTH  first source word address.
- dst_addr  in  ADDR_WIDTH  first destination word address.
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
- idle  out  1  engine in IDLE; start accepted.
- busy  out  1  copy in progress.
- done  out  1  one-cycle pulse when the copy completes.
- err  out  1  one-cycle pulse when a request is rejected.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid with ram_rd_valid.
- ram_rd_valid  in  1  RAM read response; asserted 1 cycle after ram_rd_en.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, idle=1; busy, done, err, ram_rd_en, ram_wr_en = 0; addresses, wr_data, counters = 0.
- FSM states: IDLE, RUN, DRAIN, DONE, ERR.
- Start capture (IDLE & start at edge T): latch src, dst and len; compute diff = (dst_addr - src_addr) mod 2**ADDR_WIDTH.
  - 0 < diff < len: go to ERR. Destructive forward overlap, wrap-aware. No RAM access is made.
  - len==0 or diff==0: go to DONE. No RAM access.
  - Otherwise: go to RUN.
- RUN: ram_rd_en=1 every cycle, ram_rd_addr = src+i, for i = 0..len-1. After the read with i = len-1 is issued, go to DRAIN.
- Write path (RUN and DRAIN): on a cycle with ram_rd_valid=1, drive ram_wr_en=1, ram_wr_addr = dst+j, ram_wr_data = ram_rd_data (combinational pass-through). Then increment j.
- DRAIN: no reads. After the write with j = len-1, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- ERR: err=1 for one cycle, then go to IDLE.
- Timing for len=N≥1, start sampled at edge 0:
  - reads issued in cycles 1..N;
  - writes in cycles 2..N+1;
  - done in cycle N+2;
  - busy=1 in cycles 1..N+1.
- For the len=0/diff=0 and reject paths, done or err appears in cycle 1.
- ram_rd_valid is ignored outside RUN/DRAIN; the RAM's rd_valid is unreset and may be X.
- start is ignored in every state except IDLE. Input changes during a copy have no effect.
- Read and write addresses wrap modulo 2**ADDR_WIDTH. len = 2**ADDR_WIDTH copies the whole RAM (counters are ADDR_WIDTH+1 bits).
- Invariant (assert): never ram_rd_en & ram_wr_en with ram_rd_addr==ram_wr_addr. The overlap rule guarantees this; the RAM asserts on it.
- Invariant (assert): ram_rd_valid in RUN/DRAIN only follows a cycle with ram_rd_en=1.
- Reset mid-copy: immediate return to IDLE with all outputs at reset values. Partially written destination words are left as written.

Decomposition:
- Package sim_ram_copier_pkg holds the state enum (IDLE, RUN, DRAIN, DONE, ERR) and a function overlap_bad(diff, len).
- Single module; no sub-module. The read index and write index counters are inline.

Test Plan:
- AW=8, src=0x10, dst=0x80, len=4, RAM[0x10..0x13] = A0..A3 -> RAM[0x80..0x83] = A0..A3; ram_rd_en in cycles 1-4, ram_wr_en in cycles 2-5, done in cycle 6, busy in cycles 1-5.
- src=0x20, dst=0x22, len=4 -> err pulses in cycle 1; no ram_rd_en or ram_wr_en; RAM unchanged.
- src=0x22, dst=0x20, len=4 (backward overlap, legal) -> RAM[0x20..0x23] = old RAM[0x22..0x25]; done in cycle 6.
- src=0xFE, dst=0x40, len=4 -> reads 0xFE, 0xFF, 0x00, 0x01 and writes 0x40..0x43; len=0 -> done in cycle 1 with no RAM traffic.
- len=256, src=0x00, dst=0x00 -> done in cycle 1. Then src=0x00, dst=0x80, len=0x80 -> 128 writes, done in cycle 130.
- Pulse rst_n low during cycle 3 of a len=8 copy -> outputs drop to reset values asynchronously; idle=1; a new start after release completes normally.
